// File: rtl/alu_cmd_host.sv
// Host-side initiator of the UART ALU command protocol: sends A, B, opcode into the
// TX FIFO, then waits (bounded) for one result byte from the RX FIFO.
module alu_cmd_host #(
    parameter int N_BIT   = 8,
    parameter int TIMEOUT = 1000000,
    parameter int TO_BIT  = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [N_BIT-1:0] i_op_a,
    input  logic [N_BIT-1:0] i_op_b,
    input  logic [N_BIT-1:0] i_opcode,
    input  logic             i_tx_full,
    input  logic             i_rx_empty,
    input  logic [N_BIT-1:0] i_r_data,
    output logic             o_wr_uart,
    output logic [N_BIT-1:0] o_w_data,
    output logic             o_rd_uart,
    output logic             o_busy,
    output logic             o_done,
    output logic [N_BIT-1:0] o_result,
    output logic             o_timeout
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_A   = 3'd1,
        S_SEND_B   = 3'd2,
        S_SEND_OP  = 3'd3,
        S_WAIT_RES = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_BIT-1:0]   r_op_a;
    logic [N_BIT-1:0]   r_op_b;
    logic [N_BIT-1:0]   r_opcode;
    logic [TO_BIT-1:0]  r_cnt;
    logic [N_BIT-1:0]   r_result;
    logic               r_timeout;
    logic               w_wr;
    logic               w_rd;
    logic [N_BIT-1:0]   w_byte;
    logic               w_to_hit;
    logic               w_accept;

    assign w_accept = (r_state == S_IDLE) && i_start;

    // Next-state and strobe decode; write/read strobes react to FIFO flags in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_rd        = 1'b0;
        w_byte      = '0;
        w_to_hit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rd = ~i_rx_empty;
                if (i_start) begin
                    w_state_nxt = S_SEND_A;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SEND_A: begin
                w_byte = r_op_a;
                w_wr   = ~i_tx_full;
                if (!i_tx_full) begin
                    w_state_nxt = S_SEND_B;
                end else begin
                    w_state_nxt = S_SEND_A;
                end
            end
            S_SEND_B: begin
                w_byte = r_op_b;
                w_wr   = ~i_tx_full;
                if (!i_tx_full) begin
                    w_state_nxt = S_SEND_OP;
                end else begin
                    w_state_nxt = S_SEND_B;
                end
            end
            S_SEND_OP: begin
                w_byte = r_opcode;
                w_wr   = ~i_tx_full;
                if (!i_tx_full) begin
                    w_state_nxt = S_WAIT_RES;
                end else begin
                    w_state_nxt = S_SEND_OP;
                end
            end
            S_WAIT_RES: begin
                // An arriving byte takes priority over an expiring counter.
                if (!i_rx_empty) begin
                    w_rd        = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_to_hit    = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT_RES;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand latches, loaded only on an accepted start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_opcode <= '0;
        end else if (w_accept) begin
            r_op_a   <= i_op_a;
            r_op_b   <= i_op_b;
            r_opcode <= i_opcode;
        end
    end

    // Wait counter: zero outside WAIT_RES, counts empty cycles inside it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state != S_WAIT_RES) begin
            r_cnt <= '0;
        end else if (i_rx_empty) begin
            r_cnt <= r_cnt + TO_BIT'(1);
        end
    end

    // Result and timeout flag; result only loads from WAIT_RES so IDLE drains never touch it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == S_WAIT_RES) && !i_rx_empty) begin
                r_result <= i_r_data;
            end
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_wr_uart = w_wr;
    assign o_w_data  = w_wr ? w_byte : '0;
    assign o_rd_uart = w_rd & i_rst_n;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_result  = r_result;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_alu_cmd_host.sv
// Directed self-checking bench for alu_cmd_host (TIMEOUT shortened to 16).
module tb_alu_cmd_host;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] op_a, op_b, opcode;
    logic       tx_full, rx_empty;
    logic [7:0] r_data;
    logic       wr_uart, rd_uart, busy, done, timeout;
    logic [7:0] w_data, result;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    logic [7:0] wq[$];

    alu_cmd_host #(.N_BIT(8), .TIMEOUT(16), .TO_BIT(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_op_a(op_a), .i_op_b(op_b), .i_opcode(opcode),
        .i_tx_full(tx_full), .i_rx_empty(rx_empty), .i_r_data(r_data),
        .o_wr_uart(wr_uart), .o_w_data(w_data), .o_rd_uart(rd_uart),
        .o_busy(busy), .o_done(done), .o_result(result), .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Passive monitor: logs written bytes, counts strobes, checks the always-true rules.
    always @(negedge clk) begin
        if (wr_uart) wq.push_back(w_data);
        else chk("wdata_zero", w_data, 8'h00);
        if (rd_uart) rd_cnt++;
        if (done) done_cnt++;
        if (rx_empty) chk("rd_when_empty", rd_uart, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        start = 1'b1; op_a = a; op_b = b; opcode = op;
        tick();
        start = 1'b0;
    endtask

    // Called in SEND_A with tx_full low; returns in the first WAIT_RES cycle.
    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        #1; chk("wr_a", wr_uart, 1'b1); chk("byte_a", w_data, a);
        tick();
        #1; chk("wr_b", wr_uart, 1'b1); chk("byte_b", w_data, b);
        tick();
        #1; chk("wr_op", wr_uart, 1'b1); chk("byte_op", w_data, op);
        tick();
        #1; chk("wait_nowr", wr_uart, 1'b0); chk("wait_busy", busy, 1'b1);
    endtask

    // Present a result byte in WAIT_RES; returns in IDLE.
    task automatic respond(input logic [7:0] val);
        rx_empty = 1'b0; r_data = val;
        #1; chk("rd_pulse", rd_uart, 1'b1);
        tick();
        rx_empty = 1'b1; r_data = 8'h00;
        #1; chk("done_hi", done, 1'b1); chk("result", result, {24'd0, val});
        chk("done_nord", rd_uart, 1'b0);
        tick();
        #1; chk("done_lo", done, 1'b0); chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0; start = 1'b0; op_a = 8'h00; op_b = 8'h00; opcode = 8'h00;
        tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
        tick(); tick();
        chk("rst_busy", busy, 1'b0); chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00); chk("rst_timeout", timeout, 1'b0);
        chk("rst_wr", wr_uart, 1'b0); chk("rst_wdata", w_data, 8'h00);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of SEND_B
        do_start(8'h11, 8'h22, 8'h33);
        tick();
        #1; chk("sendb_wr", wr_uart, 1'b1); chk("sendb_byte", w_data, 8'h22);
        rst_n = 1'b0;
        #1; chk("midrst_busy", busy, 1'b0); chk("midrst_wr", wr_uart, 1'b0);
        chk("midrst_wdata", w_data, 8'h00); chk("midrst_done", done, 1'b0);
        chk("midrst_rd", rd_uart, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(8'h12, 8'h34, 8'h20);
        send3(8'h12, 8'h34, 8'h20);
        respond(8'h99);

        // Full transaction with a late-ish response
        rd_cnt = 0; done_cnt = 0;
        do_start(8'h05, 8'h03, 8'h20);
        send3(8'h05, 8'h03, 8'h20);
        for (int i = 0; i < 10; i++) tick();
        #1; chk("wait10_done", done, 1'b0);
        respond(8'h08);
        chk("full_timeout", timeout, 1'b0);
        chk("full_rd_cnt", rd_cnt, 1);
        chk("full_done_cnt", done_cnt, 1);

        // TX FIFO full for 4 cycles during SEND_B
        wq.delete();
        do_start(8'h41, 8'h42, 8'h43);
        #1; chk("bp_a", w_data, 8'h41);
        tick();
        tx_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; chk("bp_stall_wr", wr_uart, 1'b0); chk("bp_stall_busy", busy, 1'b1);
            tick();
        end
        tx_full = 1'b0;
        #1; chk("bp_b", w_data, 8'h42); chk("bp_b_wr", wr_uart, 1'b1);
        tick();
        #1; chk("bp_op", w_data, 8'h43);
        tick();
        respond(8'h55);
        chk("bp_count", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("bp_q0", wq[0], 8'h41); chk("bp_q1", wq[1], 8'h42); chk("bp_q2", wq[2], 8'h43);
        end

        // No response: timeout after exactly 16 cycles
        do_start(8'h01, 8'h02, 8'h03);
        send3(8'h01, 8'h02, 8'h03);
        k = 0;
        while (!done && k < 40) begin
            tick();
            k++;
        end
        chk("to_latency", k, 16);
        chk("to_flag", timeout, 1'b1);
        chk("to_result", result, 8'h55);
        tick();
        #1; chk("to_hold", timeout, 1'b1); chk("to_idle", busy, 1'b0);
        rx_empty = 1'b0; r_data = 8'hAA;
        #1; chk("drain_rd", rd_uart, 1'b1);
        tick();
        rx_empty = 1'b1; r_data = 8'h00;
        #1; chk("drain_result", result, 8'h55); chk("drain_to", timeout, 1'b1);

        // Byte on the timeout cycle wins
        do_start(8'h0A, 8'h0B, 8'h0C);
        send3(8'h0A, 8'h0B, 8'h0C);
        for (int i = 0; i < 15; i++) tick();
        #1; chk("edge_done", done, 1'b0);
        respond(8'h77);
        chk("edge_timeout", timeout, 1'b0);

        // start while busy is ignored; start right after done is accepted
        wq.delete();
        do_start(8'h61, 8'h62, 8'h63);
        start = 1'b1; op_a = 8'hF1; op_b = 8'hF2; opcode = 8'hF3;
        send3(8'h61, 8'h62, 8'h63);
        rx_empty = 1'b0; r_data = 8'h66;
        tick();
        rx_empty = 1'b1; r_data = 8'h00;
        #1; chk("bb_done", done, 1'b1); chk("bb_result", result, 8'h66);
        op_a = 8'h71; op_b = 8'h72; opcode = 8'h73;
        tick();
        chk("bb_q0", wq.size() > 0 ? wq[0] : 8'h00, 8'h61);
        chk("bb_count", wq.size(), 3);
        do_start(8'h71, 8'h72, 8'h73);
        send3(8'h71, 8'h72, 8'h73);
        respond(8'h88);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
